// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg
// Shared definitions for the iterative integer divider (div32_seq):
//   DIV_WIDTH   - operand/result width
//   DIV_CNT_W   - width of the iteration counter
//   DIV_ZERO_Q  - quotient reported for a zero divisor (all ones)
//   div_state_e - divider FSM states
// ---------------------------------------------------------------------------
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_Q = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        CALC = 2'd2,
        FIX  = 2'd3
    } div_state_e;

endpackage

// File: rtl/div32_seq_sub33.sv
// ---------------------------------------------------------------------------
// sub33
// Unsigned (W)-bit subtractor with borrow-out. The divider uses it for the
// trial subtraction (rem - divisor) and for two's-complement negation (0 - x).
// Ports:
//   a, b    in  W  minuend / subtrahend
//   diff    out W  a - b modulo 2^W
//   borrow  out 1  set when a < b (unsigned)
// ---------------------------------------------------------------------------
module sub33 #(
    parameter int W = 33
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         borrow
);

    assign {borrow, diff} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/div32_seq.sv
// ---------------------------------------------------------------------------
// div32_seq
// Iterative restoring divider, one quotient bit per clock, signed or unsigned.
// Latency is WIDTH+2 edges from the start-sampling edge to the done cycle;
// a zero divisor finishes one edge after start.
// Ports:
//   clk, rst   in   clock, synchronous active-high reset
//   start      in   request strobe, only honoured in IDLE
//   sign_mode  in   1 = two's-complement operands, 0 = unsigned
//   dividend   in   WIDTH  captured with start
//   divisor    in   WIDTH  captured with start
//   busy       out  high while an operation is in flight
//   done       out  one-cycle completion pulse
//   quotient   out  WIDTH  held until the next done
//   remainder  out  WIDTH  held until the next done
//   div_zero   out  divisor was zero, held until the next done
// ---------------------------------------------------------------------------
module div32_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sign_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    div_state_e           state_q, state_d;
    logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     quo_q, quo_d;
    logic [WIDTH-1:0]     dvs_q, dvs_d;
    logic                 sa_q, sa_d;
    logic                 sb_q, sb_d;
    logic [WIDTH-1:0]     quotient_q, quotient_d;
    logic [WIDTH-1:0]     remainder_q, remainder_d;
    logic                 div_zero_q, div_zero_d;
    logic                 done_q, done_d;

    // Trial subtraction: the shifted partial remainder needs one extra bit
    // because it can momentarily reach 2*divisor-1.
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] trial_diff;
    logic           trial_borrow;

    // Negators: quo_q is negated in both PREP (dividend) and FIX (quotient);
    // the second negator takes the divisor in PREP and the remainder in FIX.
    logic [WIDTH-1:0] negb_in;
    logic [WIDTH:0]   nega_diff, negb_diff;
    logic             nega_borrow, negb_borrow;
    logic             unused_bits;

    assign rem_sh  = {rem_q, quo_q[WIDTH-1]};
    assign negb_in = (state_q == FIX) ? rem_q : dvs_q;

    sub33 #(.W(WIDTH + 1)) u_trial (
        .a      (rem_sh),
        .b      ({1'b0, dvs_q}),
        .diff   (trial_diff),
        .borrow (trial_borrow)
    );

    sub33 #(.W(WIDTH + 1)) u_nega (
        .a      ('0),
        .b      ({1'b0, quo_q}),
        .diff   (nega_diff),
        .borrow (nega_borrow)
    );

    sub33 #(.W(WIDTH + 1)) u_negb (
        .a      ('0),
        .b      ({1'b0, negb_in}),
        .diff   (negb_diff),
        .borrow (negb_borrow)
    );

    // Top bits of the negations and the trial result are not needed: a
    // non-borrowing trial result is always below the divisor.
    assign unused_bits = ^{trial_diff[WIDTH], nega_diff[WIDTH], negb_diff[WIDTH],
                           nega_borrow, negb_borrow};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        sa_d        = sa_q;
        sb_d        = sb_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;
        done_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    quo_d   = dividend;
                    dvs_d   = divisor;
                    // Sign flags are pre-qualified with sign_mode so that the
                    // later stages need not look at the mode again.
                    sa_d    = sign_mode & dividend[WIDTH-1];
                    sb_d    = sign_mode & divisor[WIDTH-1];
                    state_d = PREP;
                end
            end
            PREP: begin
                if (dvs_q == '0) begin
                    quotient_d  = DIV_ZERO_Q;
                    remainder_d = quo_q;
                    div_zero_d  = 1'b1;
                    done_d      = 1'b1;
                    state_d     = IDLE;
                end else begin
                    // Magnitudes are treated as unsigned, so the most negative
                    // value maps onto itself and still divides correctly.
                    quo_d   = sa_q ? nega_diff[WIDTH-1:0] : quo_q;
                    dvs_d   = sb_q ? negb_diff[WIDTH-1:0] : dvs_q;
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (!trial_borrow) begin
                    rem_d = trial_diff[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + DIV_CNT_W'(1);
                if (cnt_q == DIV_CNT_W'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                quotient_d  = (sa_q ^ sb_q) ? nega_diff[WIDTH-1:0] : quo_q;
                remainder_d = sa_q ? negb_diff[WIDTH-1:0] : rem_q;
                div_zero_d  = 1'b0;
                done_d      = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            sa_q        <= 1'b0;
            sb_q        <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            sa_q        <= sa_d;
            sb_q        <= sb_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
            done_q      <= done_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_div32_seq.sv
// ---------------------------------------------------------------------------
// tb_div32_seq
// Scoreboard bench for div32_seq: each accepted start pushes its expected
// quotient/remainder/flag and completion cycle; every done pops and compares.
// ---------------------------------------------------------------------------
module tb_div32_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sign_mode;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_zero;

    div32_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sign_mode (sign_mode),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
        int           due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference model built on the language's own division operators.
    function automatic void model(input logic m, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z);
        longint la, lb;
        if (b == '0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else if (!m) begin
            q = a / b;
            r = a % b;
            z = 1'b0;
        end else begin
            la = longint'($signed(a));
            lb = longint'($signed(b));
            q  = W'(la / lb);
            r  = W'(la % lb);
            z  = 1'b0;
        end
    endfunction

    // Drive one start strobe; returns just after the sampling edge (+1).
    task automatic issue_exp(input logic m, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez);
        exp_t e;
        e.q   = eq;
        e.r   = er;
        e.z   = ez;
        e.due = cyc + 1 + ((b == '0) ? 1 : (W + 2));
        sb.push_back(e);
        sign_mode = m;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        sign_mode = 1'($urandom);
        dividend  = $urandom;
        divisor   = $urandom;
    endtask

    task automatic issue(input logic m, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] q, r;
        logic         z;
        model(m, a, b, q, r, z);
        issue_exp(m, a, b, q, r, z);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            check_eq("timeout_pending", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // Completion monitor.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check_eq("spurious_done", 64'd1, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check_eq("quotient", 64'(quotient), 64'(mon_e.q));
                check_eq("remainder", 64'(remainder), 64'(mon_e.r));
                check_eq("div_zero", 64'(div_zero), 64'(mon_e.z));
                check_eq("done_cycle", 64'(cyc), 64'(mon_e.due));
                check_eq("busy_at_done", 64'(busy), 64'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int           drops;
        logic         m;
        logic [W-1:0] a, b;

        rst       = 1'b1;
        start     = 1'b0;
        sign_mode = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_quotient", 64'(quotient), 64'd0);
        check_eq("rst_remainder", 64'(remainder), 64'd0);
        check_eq("rst_div_zero", 64'(div_zero), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Unsigned 100 / 7, busy must stay high until done.
        issue_exp(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        check_eq("busy_after_start", 64'(busy), 64'd1);
        drops = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) break;
            if (!busy) drops++;
        end
        check_eq("busy_continuous", 64'(drops), 64'd0);
        wait_idle();

        // Signed -7 / 2.
        issue_exp(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        wait_idle();

        // Overflow operands in both modes.
        issue_exp(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 1'b0);
        wait_idle();
        issue_exp(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
        wait_idle();

        // Divide by zero.
        issue_exp(1'b0, 32'h0000_1234, 32'h0, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1);
        check_eq("busy_div0", 64'(busy), 64'd1);
        wait_idle();

        // Abort 50 / 5 with reset in its tenth busy cycle (never scoreboarded).
        sign_mode = 1'b0;
        dividend  = 32'd50;
        divisor   = 32'd5;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("abort_busy", 64'(busy), 64'd0);
        check_eq("abort_done", 64'(done), 64'd0);
        check_eq("abort_quotient", 64'(quotient), 64'd0);
        check_eq("abort_remainder", 64'(remainder), 64'd0);
        check_eq("abort_div_zero", 64'(div_zero), 64'd0);
        repeat (40) @(posedge clk);
        #1;
        issue_exp(1'b0, 32'd9, 32'd4, 32'd2, 32'd1, 1'b0);
        wait_idle();

        // start held high during busy with other operands: ignored.
        issue_exp(1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0);
        sign_mode = 1'b1;
        dividend  = 32'd77;
        divisor   = 32'd3;
        start     = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle();
        repeat (5) @(posedge clk);
        #1;

        // Back-to-back: a start in the done cycle is accepted.
        issue_exp(1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) break;
        end
        issue_exp(1'b0, 32'd12345, 32'd100, 32'd123, 32'd45, 1'b0);
        wait_idle();

        // Random mix including small and zero divisors.
        for (int k = 0; k < 16; k++) begin
            m = 1'($urandom);
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = '0;
                1:       b = W'($urandom_range(1, 15));
                2:       b = -W'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            issue(m, a, b);
            wait_idle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
